// File: rtl/adc_capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : adc_capture_pkg                                                 |
// | Purpose  : Shared types and constants for the ADC probe capture buffer:   |
// |            capture state encoding and trigger-mode codes.                 |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package adc_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_READ      = 3'd4
  } state_e;

  localparam logic [1:0] TRIG_IMM   = 2'd0;
  localparam logic [1:0] TRIG_MATCH = 2'd1;
  localparam logic [1:0] TRIG_EDGE  = 2'd2;
  localparam logic [1:0] TRIG_EXT   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/capture_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : capture_ram                                                     |
// | Purpose  : Simple dual-port DEPTH x DATA_W sample store. Synchronous       |
// |            write, registered read (1-cycle latency), single clock.        |
// |            The read register only updates when re_i is high, so it holds |
// |            its word while the downstream stage is stalled.                |
// | Ports    : clk_i, we_i/waddr_i/wdata_i (write), re_i/raddr_i/rdata_o     |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module capture_ram #(
  parameter int DATA_W = 35,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/adc_capture_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : adc_capture_buffer                                              |
// | Purpose  : Armed capture engine for the ADC probe bus. Keeps a pre-trigger |
// |            history in a circular RAM, fires on immediate / masked match / |
// |            masked rising edge / external trigger, fills the post window   |
// |            and streams the DEPTH-word window oldest-first.                |
// | Ports    : clk_i, rst_n_i (async, active low), sample_en_i, data_i,       |
// |            arm_i, abort_i, trig_mode_i, trig_mask_i, trig_value_i,        |
// |            trig_ext_i, pretrig_i, armed_o, triggered_o, done_o,           |
// |            rd_valid_o, rd_data_o, rd_last_o, rd_ready_i                   |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module adc_capture_buffer
  import adc_capture_pkg::*;
#(
  parameter int DATA_W = 35,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              sample_en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic              trig_ext_i,
  input  logic [AW-1:0]     pretrig_i,
  output logic              armed_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_last_o,
  input  logic              rd_ready_i
);

  localparam logic [AW-1:0] c_LAST_IDX = AW'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       pretrig_q, pretrig_d;
  logic [AW-1:0]       post_q, post_d;
  logic [AW-1:0]       trig_addr_q, trig_addr_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   mask_q, mask_d, value_q, value_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_vld_q, prev_vld_d;
  logic [AW-1:0]       rd_addr_q, rd_addr_d;
  logic [AW:0]         iss_cnt_q, iss_cnt_d;
  logic                ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
  logic                rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                armed_q, armed_d, triggered_q, triggered_d, done_q, done_d;

  logic                w_strobe, w_trig_hit, w_load_out, w_issue;
  logic [DATA_W-1:0]   w_ram_rdata;

  assign w_strobe = sample_en_i &&
                    (state_q == ST_PREFILL || state_q == ST_WAIT_TRIG || state_q == ST_POST);

  always_comb begin
    w_trig_hit = 1'b0;
    unique case (mode_q)
      TRIG_IMM:   w_trig_hit = 1'b1;
      TRIG_MATCH: w_trig_hit = ((data_i & mask_q) == (value_q & mask_q));
      // No valid history on the first strobe after arm, so no edge can be seen.
      TRIG_EDGE:  w_trig_hit = prev_vld_q && |(data_i & ~prev_q & mask_q);
      TRIG_EXT:   w_trig_hit = trig_ext_i;
    endcase
  end

  // Two-stage readout: RAM read register, then output register. A RAM word
  // moves forward whenever the output slot is empty or being consumed; a new
  // read is issued only when the RAM stage will be free, so a stalled word is
  // never overwritten.
  assign w_load_out = ram_vld_q && (!rd_valid_q || rd_ready_i);
  assign w_issue    = (state_q == ST_READ) && !iss_cnt_q[AW] && (!ram_vld_q || w_load_out);

  capture_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (clk_i),
    .we_i    (w_strobe),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .re_i    (w_issue),
    .raddr_i (rd_addr_q),
    .rdata_o (w_ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    pretrig_d   = pretrig_q;
    post_d      = post_q;
    trig_addr_d = trig_addr_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    value_d     = value_q;
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    rd_addr_d   = rd_addr_q;
    iss_cnt_d   = iss_cnt_q;
    ram_vld_d   = ram_vld_q;
    ram_last_d  = ram_last_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    rd_last_d   = rd_last_q;

    if (w_strobe) begin
      wr_ptr_d   = wr_ptr_q + AW'(1);
      prev_d     = data_i;
      prev_vld_d = 1'b1;
    end

    if (w_issue) begin
      rd_addr_d  = rd_addr_q + AW'(1);
      iss_cnt_d  = iss_cnt_q + (AW+1)'(1);
      ram_vld_d  = 1'b1;
      ram_last_d = (iss_cnt_q == {1'b0, c_LAST_IDX});
    end else if (w_load_out) begin
      ram_vld_d = 1'b0;
    end

    if (w_load_out) begin
      rd_valid_d = 1'b1;
      rd_data_d  = w_ram_rdata;
      rd_last_d  = ram_last_q;
    end else if (rd_valid_q && rd_ready_i) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (arm_i) begin
          state_d    = ST_PREFILL;
          wr_ptr_d   = '0;
          cnt_d      = '0;
          prev_vld_d = 1'b0;
          mode_d     = trig_mode_i;
          mask_d     = trig_mask_i;
          value_d    = trig_value_i;
          // An AW-bit port cannot exceed DEPTH-1, so the clamp is inherent.
          pretrig_d  = pretrig_i;
        end
      end
      ST_PREFILL: begin
        if (w_strobe) cnt_d = cnt_q + AW'(1);
        // cnt_q == pretrig_q only holds here when pretrig is zero.
        if ((cnt_q == pretrig_q) || (w_strobe && (cnt_q + AW'(1) == pretrig_q)))
          state_d = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        if (w_strobe && w_trig_hit) begin
          trig_addr_d = wr_ptr_q;
          post_d      = c_LAST_IDX - pretrig_q;
          state_d     = (pretrig_q == c_LAST_IDX) ? ST_READ : ST_POST;
        end
      end
      ST_POST: begin
        if (w_strobe) begin
          post_d = post_q - AW'(1);
          if (post_q == AW'(1)) state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (rd_valid_q && rd_ready_i && rd_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q != ST_READ && state_d == ST_READ) begin
      rd_addr_d  = trig_addr_d - pretrig_q;
      iss_cnt_d  = '0;
      ram_vld_d  = 1'b0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end

    if (abort_i) begin
      state_d    = ST_IDLE;
      ram_vld_d  = 1'b0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end

    armed_d     = (state_d == ST_PREFILL) || (state_d == ST_WAIT_TRIG);
    triggered_d = (state_d == ST_POST) || (state_d == ST_READ);
    done_d      = (state_d == ST_READ);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      pretrig_q   <= '0;
      post_q      <= '0;
      trig_addr_q <= '0;
      mode_q      <= TRIG_IMM;
      mask_q      <= '0;
      value_q     <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      rd_addr_q   <= '0;
      iss_cnt_q   <= '0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_last_q   <= 1'b0;
      armed_q     <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      pretrig_q   <= pretrig_d;
      post_q      <= post_d;
      trig_addr_q <= trig_addr_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      rd_addr_q   <= rd_addr_d;
      iss_cnt_q   <= iss_cnt_d;
      ram_vld_q   <= ram_vld_d;
      ram_last_q  <= ram_last_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      rd_last_q   <= rd_last_d;
      armed_q     <= armed_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
    end
  end

  assign armed_o     = armed_q;
  assign triggered_o = triggered_q;
  assign done_o      = done_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_data_q;
  assign rd_last_o   = rd_last_q;

endmodule
`default_nettype wire
